// File: rtl/avalon_rw_checker.sv
// avalon_rw_checker: Avalon-MM write/readback pattern checker; `define LFSR_PATTERN_EN selects LFSR data instead of the index pattern
module avalon_rw_checker #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR      = 32'hC700_0000,
  parameter int          NUM_WORDS      = 16,
  parameter logic [31:0] PATTERN_SEED   = 32'hA5A5_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  iClk,
  input  logic                  iResetn,
  input  logic                  iStart,
  output logic                  avalonRead,
  output logic                  avalonWrite,
  output logic [ADDR_WIDTH-1:0] avalonAddr,
  output logic [3:0]            avalonBE,
  output logic                  avalonBeginTransfer,
  input  logic                  avalonWaitReq,
  input  logic                  avalonReadValid,
  input  logic [DATA_WIDTH-1:0] avalonReadData,
  output logic [DATA_WIDTH-1:0] avalonWriteData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oPass,
  output logic                  oTimeout,
  output logic [15:0]           oErrCount,
  output logic [31:0]           oFirstErrAddr
);
  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, WGAP = 3'd2, RD = 3'd3, RWAIT = 3'd4, DONE = 3'd5;
  localparam logic [15:0] LAST = 16'(NUM_WORDS - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [2:0] state;
  logic [15:0] idx, tcnt;
  logic bt, tmo;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] exp_data;
  logic start, wr_acc, rd_acc, capture, xfer, to, last;
  assign start   = iStart && (state == IDLE || state == DONE);
  assign wr_acc  = state == WR && !avalonWaitReq;
  assign rd_acc  = state == RD && !avalonWaitReq;
  assign capture = (rd_acc || state == RWAIT) && avalonReadValid;
  assign xfer    = state == WR || state == RD || state == RWAIT;
  assign to      = xfer && !wr_acc && !capture && tcnt >= TO_LAST;
  assign last    = idx == LAST;
  assign addr    = ADDR_WIDTH'(BASE_ADDR + {14'd0, idx, 2'b00});
`ifdef LFSR_PATTERN_EN
  localparam logic [31:0] SEED = (PATTERN_SEED == 32'd0) ? 32'd1 : PATTERN_SEED;
  logic [31:0] lfsr, lfsr_next;
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'd0);
  assign exp_data  = DATA_WIDTH'(lfsr);
  always_ff @(posedge iClk)
    if (!iResetn) lfsr <= SEED;
    else if (start || (wr_acc && last)) lfsr <= SEED;
    else if (wr_acc || capture) lfsr <= lfsr_next;
`else
  assign exp_data = DATA_WIDTH'(PATTERN_SEED ^ {idx, ~idx});
`endif
  assign avalonWrite         = state == WR;
  assign avalonRead          = state == RD;
  assign avalonBE            = 4'hF;
  assign avalonBeginTransfer = bt;
  assign avalonAddr          = (avalonWrite || avalonRead) ? addr : '0;
  assign avalonWriteData     = avalonWrite ? exp_data : '0;
  assign oBusy               = xfer || state == WGAP;
  assign oDone               = state == DONE;
  assign oPass               = oDone && oErrCount == 16'd0 && !tmo;
  assign oTimeout            = tmo;
  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      state         <= IDLE;
      idx           <= '0;
      tcnt          <= '0;
      bt            <= 1'b0;
      tmo           <= 1'b0;
      oErrCount     <= '0;
      oFirstErrAddr <= '0;
    end else begin
      bt   <= 1'b0;
      tcnt <= tcnt + 16'd1;
      if (start) begin
        state         <= WR;
        idx           <= '0;
        tcnt          <= '0;
        bt            <= 1'b1;
        tmo           <= 1'b0;
        oErrCount     <= '0;
        oFirstErrAddr <= '0;
      end else if (to) begin
        state <= DONE;
        tmo   <= 1'b1;
      end else if (wr_acc) begin
        state <= last ? RD : WGAP;
        idx   <= last ? 16'd0 : idx + 16'd1;
        tcnt  <= '0;
        bt    <= last;
      end else if (state == WGAP) begin
        state <= WR;
        tcnt  <= '0;
        bt    <= 1'b1;
      end else if (capture) begin
        if (avalonReadData != exp_data) begin
          oErrCount <= (oErrCount == 16'hFFFF) ? oErrCount : oErrCount + 16'd1;
          if (oErrCount == 16'd0) oFirstErrAddr <= 32'(addr);
        end
        state <= last ? DONE : RD;
        idx   <= last ? idx : idx + 16'd1;
        tcnt  <= '0;
        bt    <= !last;
      end else if (rd_acc) state <= RWAIT;
    end
  end
endmodule

// File: doc/avalon_rw_checker.md
Name: avalon_rw_checker

Overview:
- Avalon-MM traffic generator and checker that drives the Avalon side of the AXI4-Lite master bridge.
- Writes NUM_WORDS pattern words to a contiguous region, reads them back, compares, and reports pass/fail, error count and first failing address.
- Used for on-board bring-up of AXI-Lite slaves behind the bridge.
- One transfer outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, Avalon address width.
- DATA_WIDTH, 32, Avalon data width; fixed at 32, byte enables 4 bits.
- BASE_ADDR, 32'hC7000000, byte address of word 0.
- NUM_WORDS, 16, words per run; range 1..65535.
- PATTERN_SEED, 32'hA5A5_0000, pattern seed.
- TIMEOUT_CYCLES, 1024, maximum cycles one transfer may stall; range 2..65535.

Ports:
- iClk  in  1  clock
- iResetn  in  1  synchronous reset, active low
- iStart  in  1  start-run pulse; sampled only in IDLE and DONE
- avalonRead  out  1  read request
- avalonWrite  out  1  write request
- avalonAddr  out  32  byte address
- avalonBE  out  4  byte enables; always 4'hF
- avalonBeginTransfer  out  1  high in the first cycle of each transfer
- avalonWaitReq  in  1  slave stall
- avalonReadValid  in  1  read data valid
- avalonReadData  in  32  read data
- avalonWriteData  out  32  write data
- oBusy  out  1  run in progress
- oDone  out  1  run finished; held until the next start or reset
- oPass  out  1  valid while oDone: no mismatch and no timeout
- oTimeout  out  1  run aborted by a stalled transfer
- oErrCount  out  16  mismatch count; saturates at 16'hFFFF
- oFirstErrAddr  out  32  address of the first mismatch; 0 if none

Behaviour:
- Reset: one clock; reset is synchronous and active-low (iClk, iResetn).
  - All outputs go to 0 at the next edge, except avalonBE = 4'hF.
  - State goes to IDLE.
  - Reset mid-transfer drops avalonRead/avalonWrite immediately, with no completion.
- Word index i runs 0..NUM_WORDS-1.
  - Address = BASE_ADDR + 4*i, modulo 2^32; wrap-around is allowed.
  - Data = PATTERN_SEED ^ {i[15:0], ~i[15:0]}.
- States:
  - IDLE: iStart high -> WR. Set oBusy = 1, clear oDone, oPass, oTimeout, oErrCount and oFirstErrAddr, set i = 0.
  - WR: avalonWrite = 1, with address and data held stable.
    - Write accepted on the first cycle with avalonWaitReq == 0, including the first cycle (zero wait states).
    - On accept: if i == NUM_WORDS-1, go to RD with i = 0; otherwise i++ and go to WGAP.
  - WGAP: one idle cycle with avalonWrite = 0, then WR. The request is deasserted between transfers.
  - RD: avalonRead = 1, with address held.
    - Command accepted on the first cycle with avalonWaitReq == 0.
    - If avalonReadValid is high in the same cycle, data is captured there; otherwise go to RWAIT.
    - avalonRead drops after accept.
  - RWAIT: wait for avalonReadValid, then capture data.
  - After capture, compare against the expected pattern.
    - On mismatch, oErrCount increments (saturating). oFirstErrAddr is loaded only if oErrCount was 0.
    - Last word -> DONE; otherwise i++ and go to RD the next cycle.
  - DONE: oBusy = 0, oDone = 1, oPass = (oErrCount == 0) && !oTimeout. iStart -> restarts as from IDLE.
- avalonBeginTransfer: one-cycle pulse in the first cycle of each WR or RD entry.
- Timeout:
  - A per-transfer cycle counter counts from WR/RD entry to accept (and through RWAIT).
  - Reaching TIMEOUT_CYCLES sets oTimeout = 1, drops requests and goes to DONE.
- Ignored inputs:
  - iStart is ignored while oBusy.
  - avalonReadValid is ignored outside RD/RWAIT.
- NUM_WORDS == 1: one write, one read, then DONE.

Optional Feature:
- Macro: LFSR_PATTERN_EN.
- When defined:
  - Data comes from a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seeded with PATTERN_SEED (0 is replaced by 1).
  - The LFSR advances once per accepted write.
  - It is reloaded with the seed at read-phase entry and advances once per captured read.
- When undefined: the index pattern above is used and no LFSR logic is generated.

Test Plan:
- Zero-wait loopback memory, NUM_WORDS = 16, iStart -> 16 writes to C7000000..C700003C, with word 0 data A5A5_FFFF and word 1 data A5A4_FFFE (wait, computed value is A5A4_FFFE for i=1: A5A5_0000 ^ 0001_FFFE); 16 reads; oDone = 1, oPass = 1, oErrCount = 0.
- Slave with 3 wait states per access plus read data 2 cycles after accept -> address and data stay stable during stall; oPass = 1; exactly 16 avalonBeginTransfer pulses per phase.
- Memory flips bit 0 of word 5 -> oErrCount = 1, oFirstErrAddr = C7000014, oPass = 0.
- avalonWaitReq stuck high on write 2, TIMEOUT_CYCLES = 8 -> after 8 cycles oTimeout = 1, oDone = 1, oPass = 0, avalonWrite = 0.
- iResetn low for 1 cycle during read 7, then iStart -> outputs cleared at reset; a full clean run passes.
- iStart pulsed while busy -> ignored; iStart in DONE -> new run with counters cleared.
